// File: rtl/i2s_pkg.sv
// Shared frame geometry for the I2S transmitter: 64-bit frames made of two 32-bit slots.
package i2s_pkg;

    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS  = 32;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

    localparam bit_cnt_t LAST_BIT = bit_cnt_t'(FRAME_BITS - 1);

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between a sample source (master) and the I2S transmitter (slave).
interface i2s_tx_if #(
    parameter int DATA_W = 16
);

    logic [DATA_W-1:0] sample_left;
    logic [DATA_W-1:0] sample_right;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/i2s_clkgen.sv
// Bit-clock and word-select generator: divides clk_in down to sclk and tracks the bit position in the frame.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic     clk_in,
    input  logic     reset,
    output logic     sclk,
    output logic     lrck,
    output bit_cnt_t bit_cnt,
    output logic     fall_tick,
    output logic     load_tick
);

    localparam int               DIV_W    = $clog2(SCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    bit_cnt_t         bit_cnt_q, bit_cnt_d;
    logic             sclk_q, sclk_d;
    logic             lrck_q, lrck_d;

    // sclk and lrck are derived from the next counter values so the
    // registered outputs line up exactly with the counters they describe.
    always_comb begin
        fall_tick = (div_cnt_q == DIV_LAST);
        load_tick = fall_tick && (bit_cnt_q == LAST_BIT);
        div_cnt_d = fall_tick ? '0 : div_cnt_q + DIV_W'(1);
        bit_cnt_d = fall_tick ? bit_cnt_q + bit_cnt_t'(1) : bit_cnt_q;
        sclk_d    = (div_cnt_d >= DIV_HALF);
        lrck_d    = (int'(bit_cnt_d) >= SLOT_BITS);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sclk_q    <= sclk_d;
            lrck_q    <= lrck_d;
        end
    end

    assign sclk    = sclk_q;
    assign lrck    = lrck_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: holding register + shadow pair, serialised MSB first with the I2S one-bit delay.
// Define I2S_TX_UNDERRUN_MUTE_EN to send silence on underrun instead of repeating the last pair.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV = 4,
    parameter int DATA_W   = 16
) (
    input  logic     clk_in,
    input  logic     reset,
    i2s_tx_if.slave  smp,
    input  logic     underrun_clr,
    output logic     underrun,
    output logic     sclk,
    output logic     lrck,
    output logic     sdata
);

    logic     fall_tick;
    logic     load_tick;
    bit_cnt_t bit_cnt;
    bit_cnt_t bit_nxt;

    i2s_clkgen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_clkgen (
        .clk_in    (clk_in),
        .reset     (reset),
        .sclk      (sclk),
        .lrck      (lrck),
        .bit_cnt   (bit_cnt),
        .fall_tick (fall_tick),
        .load_tick (load_tick)
    );

    logic [DATA_W-1:0] hold_left_q, hold_left_d;
    logic [DATA_W-1:0] hold_right_q, hold_right_d;
    logic [DATA_W-1:0] shadow_left_q, shadow_left_d;
    logic [DATA_W-1:0] shadow_right_q, shadow_right_d;
    logic              full_q, full_d;
    logic              underrun_q, underrun_d;
    logic              sdata_q, sdata_d;
    logic              accept;
    logic [DATA_W-1:0] left_sh;
    logic [DATA_W-1:0] right_sh;

    always_comb begin
        accept         = smp.sample_valid && !full_q;
        hold_left_d    = hold_left_q;
        hold_right_d   = hold_right_q;
        shadow_left_d  = shadow_left_q;
        shadow_right_d = shadow_right_q;
        full_d         = full_q;
        underrun_d     = underrun_q;
        sdata_d        = sdata_q;
        bit_nxt        = bit_cnt + bit_cnt_t'(1);
        left_sh        = shadow_left_q << (bit_nxt - bit_cnt_t'(1));
        right_sh       = shadow_right_q << (bit_nxt - bit_cnt_t'(SLOT_BITS + 1));

        // Clear first so a same-cycle underrun event overrides it.
        if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        if (load_tick) begin
            if (full_q) begin
                shadow_left_d  = hold_left_q;
                shadow_right_d = hold_right_q;
                full_d         = 1'b0;
            end else begin
                underrun_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                shadow_left_d  = '0;
                shadow_right_d = '0;
`endif
            end
        end

        // An accept can only coincide with load_tick when empty, so it
        // always lands in the holding register for the following frame.
        if (accept) begin
            hold_left_d  = smp.sample_left;
            hold_right_d = smp.sample_right;
            full_d       = 1'b1;
        end

        if (fall_tick) begin
            if (int'(bit_nxt) >= 1 && int'(bit_nxt) <= DATA_W) begin
                sdata_d = left_sh[DATA_W-1];
            end else if (int'(bit_nxt) >= SLOT_BITS + 1 && int'(bit_nxt) <= SLOT_BITS + DATA_W) begin
                sdata_d = right_sh[DATA_W-1];
            end else begin
                sdata_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            hold_left_q    <= '0;
            hold_right_q   <= '0;
            shadow_left_q  <= '0;
            shadow_right_q <= '0;
            full_q         <= 1'b0;
            underrun_q     <= 1'b0;
            sdata_q        <= 1'b0;
        end else begin
            hold_left_q    <= hold_left_d;
            hold_right_q   <= hold_right_d;
            shadow_left_q  <= shadow_left_d;
            shadow_right_q <= shadow_right_d;
            full_q         <= full_d;
            underrun_q     <= underrun_d;
            sdata_q        <= sdata_d;
        end
    end

    assign smp.sample_ready = !full_q;
    assign underrun         = underrun_q;
    assign sdata            = sdata_q;

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter SCLK_DIV, default 4: clk_in cycles per SCLK period; even, >= 2.
REQ-002 Parameter DATA_W, default 16: sample width per channel; 1..32.
REQ-003 clk_in  input  1  codec master clock, forwarded unchanged by the MCLK DDR output buffer; sole clock of this block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sample_left  input  DATA_W  left sample, two's complement.
REQ-006 sample_right  input  DATA_W  right sample, two's complement.
REQ-007 sample_valid  input  1  sample pair present.
REQ-008 sample_ready  output  1  holding register empty; a transfer occurs when valid && ready on a clk_in edge.
REQ-009 underrun_clr  input  1  clears the underrun flag.
REQ-010 underrun  output  1  sticky: a frame started with no new sample.
REQ-011 sclk  output  1  I2S bit clock, registered.
REQ-012 lrck  output  1  I2S word select, registered; 0 = left, 1 = right.
REQ-013 sdata  output  1  I2S serial data, registered.

Function
REQ-014 div_cnt SHALL count 0..SCLK_DIV-1 and wrap. sclk SHALL be 0 for div_cnt < SCLK_DIV/2 and 1 otherwise. fall_tick = (div_cnt == SCLK_DIV-1).
REQ-015 bit_cnt SHALL count 0..63, incrementing on each fall_tick and wrapping 63->0. A frame is 64 SCLK periods, or 64*SCLK_DIV clk_in cycles.
REQ-016 lrck SHALL be 0 while bit_cnt is 0..31 and 1 while bit_cnt is 32..63, changing in the same cycle as the sclk falling edge.
REQ-017 I2S one-bit delay: in the left slot, bit_cnt 1..DATA_W SHALL carry left MSB..LSB. In the right slot, bit_cnt 33..32+DATA_W SHALL carry right MSB..LSB. All other bit positions SHALL be 0.
REQ-018 sdata SHALL change only on sclk falling edges; a receiver samples it on sclk rising edges.
REQ-019 Buffering is one holding register plus one shadow shift register. An accept loads the holding register and sets full.
REQ-020 sample_ready SHALL equal !full.
REQ-021 load_tick = fall_tick && bit_cnt == 63.
  - full at load_tick: shadow <= holding; full <= 0.
  - !full at load_tick: underrun <= 1; shadow is handled per REQ-027.
REQ-022 Accept and load_tick in the same cycle: only possible with full = 0. This counts as an underrun for the new frame; the accepted pair goes to the holding register for the next frame.
REQ-023 underrun_clr and an underrun event in the same cycle: set wins.
REQ-024 Latency: a pair accepted at least 1 cycle before load_tick SHALL appear as the left MSB at the sclk falling edge where bit_cnt goes 0->1.

Reset
REQ-025 On reset: div_cnt = 0, bit_cnt = 0, sclk = 0, lrck = 0, sdata = 0, shadow = 0, full = 0, sample_ready = 1, underrun = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame and drop any held sample. The first load_tick after reset release SHALL occur 64*SCLK_DIV-1 cycles later.

Configuration
REQ-027 I2S_TX_UNDERRUN_MUTE_EN:
  - Defined: an underrun frame SHALL load shadow with 0, so both channels are silent.
  - Undefined: an underrun frame SHALL keep the previous shadow value, so the last pair repeats.
  - In both cases the underrun flag SHALL be set.

Structure
REQ-028 Package i2s_pkg SHALL hold FRAME_BITS = 64, SLOT_BITS = 32 and the bit_cnt width constant.
REQ-029 Sub-module i2s_clkgen SHALL contain div_cnt, bit_cnt, sclk, lrck, fall_tick and load_tick. i2s_tx SHALL contain the buffering and serialiser.

Verification (SCLK_DIV = 4, DATA_W = 16)
REQ-030 Reset, then idle 600 cycles -> sclk period 4 cycles, lrck period 256 cycles, sdata stays 0, underrun = 1 after cycle 255.
REQ-031 Write left = 16'hA5A5, right = 16'h5A5A at cycle 10 -> sample_ready goes 0 at cycle 11 and returns to 1 after cycle 255. In frame 2, rising-edge captures give A5A5 at bits 1..16 with lrck = 0, and 5A5A at bits 33..48 with lrck = 1.
REQ-032 Back-to-back pairs 16'h8000/16'h7FFF and 16'h0001/16'hFFFF, valid held high -> second pair is stalled until the first load_tick, then transmitted in the following frame; underrun stays 0.
REQ-033 After one pair, supply no further data -> next frame is all zeros with MUTE_EN defined, or a repeat of the same pair without it; underrun = 1; pulsing underrun_clr for 1 cycle -> 0.
REQ-034 Assert reset at cycle 130 of a frame with full = 1 -> outputs return to reset values next cycle, sample_ready = 1, and the held sample is never transmitted.
REQ-035 Assert valid exactly in the load_tick cycle with full = 0 -> underrun = 1; the pair appears in the next frame.
